// File: rtl/capture_mem_writer_if.sv
// Capture memory write port shared between capture_mem_writer and the memory.
//
// Handshake: mem_wr_en is a one-cycle valid with no ready; the memory must
// accept every write in the cycle it is presented. mem_wr_addr and mem_wr_data
// are only meaningful while mem_wr_en is high and hold their value otherwise.
interface capture_mem_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17
);
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    modport master (
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        input mem_wr_en,
        input mem_wr_addr,
        input mem_wr_data
    );
endinterface

// File: rtl/capture_mem_writer.sv
// Capture memory writer: synchronises the ADC sample clock into clk-domain
// strobes, writes each sample into a circular capture buffer and keeps the
// write pointer and the re-trigger timeout counter for the acquisition FSM.
module capture_mem_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 51200,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  adc_clk_in,
    input  logic [DATA_W-1:0]     adc_data,
    input  logic                  adc_clk_enable_n,
    input  logic                  restart_mem_n,
    input  logic                  restart_count_n,
    output logic [ADDR_W-1:0]     address,
    output logic [CNT_W-1:0]      count,
    output logic                  frame_done,
    capture_mem_writer_if.master  mem
);

    // "Frame full" marker and the last real memory location.
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              s1;
    logic              s2;
    logic              s3;
    logic              adc_edge;
    logic              strobe;
    logic              frame_full;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // Two-flop synchroniser for the ADC clock plus a delay flop for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= adc_clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // One strobe per ADC rising edge; edges seen while disabled are dropped.
    assign adc_edge   = s2 & ~s3;
    assign strobe     = adc_edge & adc_clk_enable_n;
    assign frame_full = (address == DEPTH_A);

    // Write path and pointer: restart wins over a strobe; a full frame wraps
    // to location 0 on the next sample, giving a circular pre-trigger buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            frame_done <= 1'b0;
        end else if (!restart_mem_n) begin
            address    <= '0;
            wr_en_q    <= 1'b0;
            frame_done <= 1'b0;
        end else if (strobe) begin
            wr_en_q    <= 1'b1;
            wr_data_q  <= adc_data;
            wr_addr_q  <= frame_full ? '0 : address;
            address    <= frame_full ? ADDR_W'(1) : address + ADDR_W'(1);
            frame_done <= (address == LAST_A);
        end else begin
            wr_en_q    <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    // Timeout counter: counts strobes regardless of restart_mem_n, saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!restart_count_n) begin
            count <= '0;
        end else if (strobe && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign mem.mem_wr_en   = wr_en_q;
    assign mem.mem_wr_addr = wr_addr_q;
    assign mem.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_capture_mem_writer.sv
// Testbench for capture_mem_writer: directed vector table, hand-written corner
// sequences and a randomized run checked against an edge-level reference model.
// The frame length and counter width are shortened so that a full wrap and
// counter saturation fit in a short run.
module tb_capture_mem_writer;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 17;
    localparam int DEPTH   = 400;
    localparam int CNT_W   = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              adc_clk_in = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              adc_clk_enable_n = 1'b1;
    logic              restart_mem_n = 1'b1;
    logic              restart_count_n = 1'b1;
    logic [ADDR_W-1:0] address;
    logic [CNT_W-1:0]  count;
    logic              frame_done;

    capture_mem_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

    capture_mem_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .adc_clk_in       (adc_clk_in),
        .adc_data         (adc_data),
        .adc_clk_enable_n (adc_clk_enable_n),
        .restart_mem_n    (restart_mem_n),
        .restart_count_n  (restart_count_n),
        .address          (address),
        .count            (count),
        .frame_done       (frame_done),
        .mem              (mem_bus.master)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one call per ADC edge) ----------------
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int m_ptr = 0;
    int m_cnt = 0;
    int m_fd  = 0;

    task automatic model_edge(input bit en_n, input bit rm_n, input bit rc_n, input logic [DATA_W-1:0] d);
        int wa;
        if (!rm_n) begin
            m_ptr = 0;
        end else if (en_n) begin
            wa = m_ptr % DEPTH;
            exp_q.push_back({ADDR_W'(wa), d});
            m_ptr = wa + 1;
            if (m_ptr == DEPTH) m_fd++;
        end
        if (!rc_n) m_cnt = 0;
        else if (en_n && m_cnt < CNT_MAX) m_cnt++;
    endtask

    // ---------------- scoreboard monitor ----------------
    int n_wr = 0;
    int n_fd = 0;
    logic [ADDR_W+DATA_W-1:0] exp_e;

    always @(negedge clk) begin
        if (mem_bus.mem_wr_en === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write (t=%0t)",
                         mem_bus.mem_wr_addr, mem_bus.mem_wr_data, $time);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_bus.mem_wr_addr), 32'(exp_e[ADDR_W+DATA_W-1:DATA_W]));
                check("wr_data", 32'(mem_bus.mem_wr_data), 32'(exp_e[DATA_W-1:0]));
            end
        end
        if (frame_done === 1'b1) n_fd++;
    end

    // ---------------- driver ----------------
    // One ADC clock period: controls and data are set at the rising edge and
    // held for the whole period; the rising edge lands at a random sub-cycle phase.
    task automatic adc_edge(input bit en_n, input bit rm_n, input bit rc_n,
                            input logic [DATA_W-1:0] d, input int hi, input int lo);
        @(negedge clk);
        adc_clk_enable_n = en_n;
        restart_mem_n    = rm_n;
        restart_count_n  = rc_n;
        adc_data         = d;
        model_edge(en_n, rm_n, rc_n, d);
        #($urandom_range(0, 4));
        adc_clk_in = 1'b1;
        repeat (hi) @(negedge clk);
        adc_clk_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit                en_n;
        bit                rm_n;
        bit                rc_n;
        logic [DATA_W-1:0] d;
        int                exp_addr;
        int                exp_cnt;
        int                exp_wr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int fd0;
        int lat;
        bit found;

        //                en  rm  rc  data   addr cnt wr
        tbl[0] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1, 1, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h11, 1, 1, 0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h3C, 2, 2, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h77, 0, 3, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h42, 1, 0, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h99, 0, 0, 0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 8'hE1, 1, 1, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h5A, 0, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_address", 32'(address), 0);
        check("rst_count", 32'(count), 0);
        check("rst_wr_en", 32'(mem_bus.mem_wr_en), 0);
        check("rst_wr_addr", 32'(mem_bus.mem_wr_addr), 0);
        check("rst_wr_data", 32'(mem_bus.mem_wr_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors
        foreach (tbl[i]) begin
            w0 = n_wr;
            adc_edge(tbl[i].en_n, tbl[i].rm_n, tbl[i].rc_n, tbl[i].d, 2, 2);
            check($sformatf("vec%0d_address", i), 32'(address), tbl[i].exp_addr);
            check($sformatf("vec%0d_count", i), 32'(count), tbl[i].exp_cnt);
            check($sformatf("vec%0d_writes", i), n_wr - w0, tbl[i].exp_wr);
        end

        // Synchroniser timing: one edge held high 10 clk gives one write on the
        // third clk edge after the rising edge.
        @(negedge clk);
        adc_clk_enable_n = 1'b1;
        restart_mem_n    = 1'b1;
        restart_count_n  = 1'b1;
        adc_data         = 8'hC3;
        model_edge(1'b1, 1'b1, 1'b1, 8'hC3);
        w0 = n_wr;
        lat = 0;
        found = 1'b0;
        #1 adc_clk_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!found && mem_bus.mem_wr_en === 1'b1) begin
                lat = i;
                found = 1'b1;
            end
        end
        adc_clk_in = 1'b0;
        repeat (4) @(negedge clk);
        check("sync_latency", lat, 3);
        check("sync_single_write", n_wr - w0, 1);

        // Free-run capture over a full frame plus wrap, ADC period 8 clk, ramp data
        adc_edge(1'b1, 1'b0, 1'b1, 8'h00, 4, 4);
        check("freerun_start_address", 32'(address), 0);
        fd0 = n_fd;
        for (int i = 0; i < DEPTH; i++) adc_edge(1'b1, 1'b1, 1'b1, DATA_W'(i), 4, 4);
        check("freerun_full_address", 32'(address), DEPTH);
        check("freerun_frame_done_once", n_fd - fd0, 1);
        check("freerun_all_written", exp_q.size(), 0);
        adc_edge(1'b1, 1'b1, 1'b1, 8'hEE, 4, 4);
        check("wrap_wr_addr", 32'(mem_bus.mem_wr_addr), 0);
        check("wrap_address", 32'(address), 1);
        check("wrap_no_frame_done", n_fd - fd0, 1);

        // Restart priority: restart_mem_n low in the strobe cycle at address 300
        for (int i = 0; i < 299; i++) adc_edge(1'b1, 1'b1, 1'b1, DATA_W'($urandom), 2, 2);
        check("prio_address_300", 32'(address), 300);
        @(negedge clk);
        adc_data = 8'h5D;
        #1 adc_clk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        restart_mem_n = 1'b0;
        model_edge(1'b1, 1'b0, 1'b1, 8'h5D);
        @(negedge clk);
        check("prio_address_cleared", 32'(address), 0);
        check("prio_no_write", 32'(mem_bus.mem_wr_en), 0);
        restart_mem_n = 1'b1;
        adc_clk_in = 1'b0;
        repeat (2) @(negedge clk);
        check("prio_count", 32'(count), m_cnt);
        adc_edge(1'b1, 1'b1, 1'b1, 8'h6A, 2, 2);
        check("prio_first_wr_addr", 32'(mem_bus.mem_wr_addr), 0);
        check("prio_address_after", 32'(address), 1);

        // Timeout counter with restart_mem_n low, then saturation
        adc_edge(1'b1, 1'b0, 1'b0, 8'h00, 2, 2);
        check("timeout_cleared", 32'(count), 0);
        w0 = n_wr;
        for (int i = 0; i < 1000; i++) adc_edge(1'b1, 1'b0, 1'b1, DATA_W'($urandom), 2, 2);
        check("timeout_count_1000", 32'(count), 1000);
        check("timeout_no_writes", n_wr - w0, 0);
        check("timeout_address_held", 32'(address), 0);
        for (int i = 0; i < 23; i++) adc_edge(1'b1, 1'b0, 1'b1, 8'h00, 2, 2);
        check("count_at_max", 32'(count), CNT_MAX);
        for (int i = 0; i < 3; i++) adc_edge(1'b1, 1'b0, 1'b1, 8'h00, 2, 2);
        check("count_saturated", 32'(count), CNT_MAX);

        // Asynchronous reset mid-burst, away from any clk edge
        for (int i = 0; i < 50; i++) adc_edge(1'b1, 1'b1, 1'b1, DATA_W'($urandom), 2, 2);
        check("pre_reset_address", 32'(address), 50);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset_address", 32'(address), 0);
        check("areset_count", 32'(count), 0);
        check("areset_wr_en", 32'(mem_bus.mem_wr_en), 0);
        check("areset_wr_addr", 32'(mem_bus.mem_wr_addr), 0);
        check("areset_wr_data", 32'(mem_bus.mem_wr_data), 0);
        check("areset_frame_done", 32'(frame_done), 0);
        m_ptr = 0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        adc_edge(1'b1, 1'b1, 1'b1, 8'h81, 2, 2);
        check("post_reset_wr_addr", 32'(mem_bus.mem_wr_addr), 0);
        check("post_reset_address", 32'(address), 1);
        check("post_reset_count", 32'(count), 1);

        // Randomized edges against the model
        for (int i = 0; i < 300; i++) begin
            adc_edge($urandom_range(0, 3) != 0, $urandom_range(0, 19) != 0,
                     $urandom_range(0, 39) != 0, DATA_W'($urandom),
                     $urandom_range(2, 5), $urandom_range(2, 4));
            check("rand_address", 32'(address), m_ptr);
            check("rand_count", 32'(count), m_cnt);
        end

        // Final report
        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_done_total", n_fd, m_fd);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/capture_mem_writer.md
Name: capture_mem_writer

Overview:
- Downstream/companion stage of the acquisition state machine.
- Turns the free-running ADC clock into system-clock sample strobes and writes each ADC sample into capture memory.
- Produces the write pointer `address`, which the state machine compares against the frame length, and the timeout counter `count`, which the state machine uses as its re-trigger timeout.
- Obeys the state machine's `restart_mem_n`, `restart_count_n` and `adc_clk_enable_n` controls.

Parameters:
- DATA_W, 8: ADC sample width.
- ADDR_W, 17: write pointer width.
- DEPTH, 51200: frame length in samples; memory locations 0..DEPTH-1.
- CNT_W, 16: timeout counter width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- adc_clk_in  in  1  ADC sample clock, asynchronous to clk, period >= 4 clk cycles
- adc_data  in  DATA_W  ADC output, stable around the adc_clk_in rising edge plus the synchroniser delay
- adc_clk_enable_n  in  1  low = suppress sample strobes (resample)
- restart_mem_n  in  1  low = hold pointer at 0, no writes
- restart_count_n  in  1  low = clear timeout counter
- address  out  ADDR_W  write pointer, range 0..DEPTH
- count  out  CNT_W  strobes counted since last clear
- mem_wr_en  out  1  one-cycle memory write strobe
- mem_wr_addr  out  ADDR_W  memory write address, always < DEPTH
- mem_wr_data  out  DATA_W  memory write data
- frame_done  out  1  one-cycle pulse when address becomes DEPTH

Behaviour:
- Reset: synchroniser flops s1, s2, s3 = 0. All outputs = 0.
- Strobe generation: adc_clk_in passes through 2-flop synchroniser s1→s2; s3 holds the previous s2.
  - edge = s2 & ~s3.
  - strobe = edge & adc_clk_enable_n.
  - Exactly one strobe per ADC rising edge; it appears 2–3 clk after that edge.
  - While adc_clk_enable_n = 0, edges are discarded, not deferred.
- Write path: all outputs are registered and updated on the clk edge ending the strobe cycle.
  - If strobe & restart_mem_n:
    - mem_wr_en = 1, mem_wr_data = adc_data.
    - mem_wr_addr = (address == DEPTH) ? 0 : address.
    - address = (address == DEPTH) ? 1 : address + 1.
  - Otherwise mem_wr_en = 0; mem_wr_addr and mem_wr_data hold their previous values.
  - Write latency: 1 clk from the strobe cycle.
- Pointer semantics:
  - address == DEPTH means "frame full" and is held until the next accepted strobe or a restart.
  - While restart_mem_n stays high, address cycles continuously: 0..DEPTH, then 1..DEPTH, and so on.
  - This gives a circular pre-trigger buffer.
- frame_done = 1 for exactly the cycle after address transitions to DEPTH; 0 otherwise.
- restart_mem_n = 0, level-sensitive, each clk:
  - address = 0, mem_wr_en = 0, frame_done = 0.
  - Any concurrent strobe is dropped.
  - restart_mem_n overrides strobe.
- Counter:
  - If restart_count_n = 0: count = 0. This overrides strobe.
  - Else if strobe: count = count + 1, saturating at 2^CNT_W-1; no wrap.
  - count keeps running while restart_mem_n = 0; this is required for the re-trigger timeout.
- Independence: restart_mem_n and restart_count_n act independently; both low clears both.
- Reset mid-frame: immediate clear. After release, the first write goes to address 0.

Test Plan:
- Free-run capture: adc_clk_in period 8 clk, data = ramp 0,1,2…, all controls high → mem_wr_en pulses every 8 clk at addresses 0,1,2… with data matching the ramp. After 51200 writes, address = 51200 and frame_done pulses once. The next write goes to mem_wr_addr = 0 and address = 1.
- Restart priority: assert restart_mem_n low in the same cycle as a strobe with address = 300 → no write and address = 0 next cycle. After release, the first write has mem_wr_addr = 0.
- Resample: hold adc_clk_enable_n low across one ADC edge → no write and count unchanged. The next edge writes normally.
- Timeout counter: restart_count_n pulse low, then 1000 ADC edges with restart_mem_n low → count = 1000 and mem_wr_en never asserted. Preload count to 65535 → count stays at 65535 on further strobes.
- Synchroniser timing: single adc_clk_in rising edge, held high 10 clk → exactly one mem_wr_en, 3–4 clk after the edge.
- Async reset at address = 20000 mid-burst → all outputs = 0 immediately, with no clk edge required. After release, writes restart at address 0.
